f_fetch_stage: RTL and testbench

Fetch stage and F/D pipeline register for the five-stage MIPS core. Holds the program counter, presents it to instruction memory, and each cycle loads the D-stage next-PC selection, while latching the fetched instruction and its PC into the F/D register for decode. Sits directly upstream of the decode-stage next-PC logic and consumes its `next_PC`. Honors the hazard-unit stall and keeps MIPS delay-slot semantics, so it never flushes.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/fd_pipe_reg.sv | 21 ++
 rtl/f_fetch_stage.sv | 65 ++++++
 tb/tb_f_fetch_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and the F/D pipeline bundle for the five-stage MIPS core.
// Address-range helper serves the optional FETCH_ALIGN_CHECK_EN build.
package mips_pkg;

    localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;
    localparam logic [31:0] IM_BASE      = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT     = 32'h0000_6FFF;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        exc_adel;
    } fd_t;

    localparam fd_t FD_RESET = '{
        pc:       32'h0,
        pc4:      32'h0,
        instr:    NOP,
        valid:    1'b0,
        exc_adel: 1'b0
    };

    // Misaligned or outside the instruction-memory window
    function automatic logic fetch_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
    endfunction

endpackage

// File: rtl/fd_pipe_reg.sv
// F/D pipeline register bank: stall-enabled, asynchronously reset.
// Reset loads a bubble (NOP, invalid, no exception).
module fd_pipe_reg
    import mips_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  fd_t  d,
    output fd_t  q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= FD_RESET;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/f_fetch_stage.sv
// Fetch stage: PC register, next-PC load and F/D register; never flushes.
// Define FETCH_ALIGN_CHECK_EN to flag misaligned/out-of-range fetches as AdEL.
module f_fetch_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] next_PC,
    input  logic [31:0] F_Instr,
    output logic [31:0] F_PC,
    output logic [31:0] F_Pc4,
    output logic [31:0] D_PC,
    output logic [31:0] D_Pc4,
    output logic [31:0] D_Instr,
    output logic        D_valid,
    output logic        D_ExcAdEL
);

    logic [31:0] pc;
    logic        fault;
    fd_t         fd_d;
    fd_t         fd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= PC_RESET_VAL;
        end else if (!stall) begin
            pc <= next_PC;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign fault = fetch_fault(pc);
`else
    assign fault = 1'b0;
`endif

    // A faulting fetch still records its PC but carries a NOP into decode
    always_comb begin
        fd_d          = FD_RESET;
        fd_d.pc       = pc;
        fd_d.pc4      = pc + 32'd4;
        fd_d.instr    = fault ? NOP : F_Instr;
        fd_d.valid    = 1'b1;
        fd_d.exc_adel = fault;
    end

    fd_pipe_reg u_fd (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .d     (fd_d),
        .q     (fd_q)
    );

    assign F_PC      = pc;
    assign F_Pc4     = pc + 32'd4;
    assign D_PC      = fd_q.pc;
    assign D_Pc4     = fd_q.pc4;
    assign D_Instr   = fd_q.instr;
    assign D_valid   = fd_q.valid;
    assign D_ExcAdEL = fd_q.exc_adel;

endmodule

// File: tb/tb_f_fetch_stage.sv
// Directed bench for f_fetch_stage with a behavioural pipeline model.
// Honors FETCH_ALIGN_CHECK_EN when it is defined for the build.
module tb_f_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] next_PC = 32'h0;
    logic [31:0] F_Instr;
    logic [31:0] F_PC, F_Pc4, D_PC, D_Pc4, D_Instr;
    logic        D_valid, D_ExcAdEL;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    logic [31:0] m_pc, m_dpc, m_dpc4, m_dinstr;
    logic        m_dvalid, m_dexc;

    f_fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .next_PC   (next_PC),
        .F_Instr   (F_Instr),
        .F_PC      (F_PC),
        .F_Pc4     (F_Pc4),
        .D_PC      (D_PC),
        .D_Pc4     (D_Pc4),
        .D_Instr   (D_Instr),
        .D_valid   (D_valid),
        .D_ExcAdEL (D_ExcAdEL)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    always_comb F_Instr = imem(F_PC);

    function automatic logic bad_addr(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFF);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'h3000;
        m_dpc    = 32'h0;
        m_dpc4   = 32'h0;
        m_dinstr = 32'h0;
        m_dvalid = 1'b0;
        m_dexc   = 1'b0;
    endtask

    // One clock: drive inputs, advance model at the edge, settle to negedge
    task automatic cycle(input logic s, input logic [31:0] npc);
        logic f;
        stall   = s;
        next_PC = npc;
        @(posedge clk);
        if (!reset && !s) begin
            f        = bad_addr(m_pc);
            m_dpc    = m_pc;
            m_dpc4   = m_pc + 32'd4;
            m_dinstr = f ? 32'h0 : imem(m_pc);
            m_dexc   = f;
            m_dvalid = 1'b1;
            m_pc     = npc;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("F_PC", F_PC, m_pc);
            chk("F_Pc4", F_Pc4, m_pc + 32'd4);
            chk("D_PC", D_PC, m_dpc);
            chk("D_Pc4", D_Pc4, m_dpc4);
            chk("D_Instr", D_Instr, m_dinstr);
            chk("D_valid", {31'b0, D_valid}, {31'b0, m_dvalid});
            chk("D_ExcAdEL", {31'b0, D_ExcAdEL}, {31'b0, m_dexc});
        end
    end

    initial begin
        model_reset();
        #1 reset = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_F_PC", F_PC, 32'h3000);
        chk("rst_F_Pc4", F_Pc4, 32'h3004);
        chk("rst_D_Instr", D_Instr, 32'h0);
        chk("rst_D_valid", {31'b0, D_valid}, 32'h0);
        reset = 1'b0;

        cycle(1'b0, m_pc + 32'd4);
        chk("first_D_PC", D_PC, 32'h3000);
        chk("first_D_valid", {31'b0, D_valid}, 32'h1);
        chk("first_F_PC", F_PC, 32'h3004);
        cycle(1'b0, m_pc + 32'd4);
        chk("seq_F_PC", F_PC, 32'h3008);

        // Branch in D at 0x3004, delay slot 0x3008 in F
        cycle(1'b0, 32'h3040);
        chk("slot_D_PC", D_PC, 32'h3008);
        chk("slot_D_Instr", D_Instr, imem(32'h3008));
        chk("br_F_PC", F_PC, 32'h3040);

        cycle(1'b0, 32'h3010);
        chk("to_3010", F_PC, 32'h3010);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'h3000);
            chk("stall_F_PC", F_PC, 32'h3010);
            chk("stall_D_PC", D_PC, 32'h3040);
            chk("stall_D_Instr", D_Instr, imem(32'h3040));
        end
        cycle(1'b0, 32'h3000);
        chk("jump_F_PC", F_PC, 32'h3000);
        chk("resume_D_PC", D_PC, 32'h3010);
        cycle(1'b0, m_pc + 32'd4);
        cycle(1'b0, m_pc + 32'd4);

        cycle(1'b0, 32'hFFFF_FFFC);
        chk("wrap_F_Pc4", F_Pc4, 32'h0);
        cycle(1'b0, 32'h3000);
        chk("wrap_D_PC", D_PC, 32'hFFFF_FFFC);
        chk("wrap_D_Pc4", D_Pc4, 32'h0);

        cycle(1'b0, 32'h3002);
        cycle(1'b0, 32'h3004);
        chk("mis_D_PC", D_PC, 32'h3002);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_D_Instr", D_Instr, 32'h0);
        chk("mis_exc", {31'b0, D_ExcAdEL}, 32'h1);
`else
        chk("mis_D_Instr", D_Instr, imem(32'h3002));
        chk("mis_exc", {31'b0, D_ExcAdEL}, 32'h0);
`endif
        cycle(1'b0, 32'h7000);
        cycle(1'b0, 32'h6FFC);
        chk("oor_D_PC", D_PC, 32'h7000);
        cycle(1'b0, 32'h3000);
        chk("edge_D_PC", D_PC, 32'h6FFC);
        chk("edge_exc", {31'b0, D_ExcAdEL}, 32'h0);
        cycle(1'b0, 32'h3100);

        // Asynchronous reset between edges, with stall also high
        #2;
        stall = 1'b1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_F_PC", F_PC, 32'h3000);
        chk("mid_D_PC", D_PC, 32'h0);
        chk("mid_D_Pc4", D_Pc4, 32'h0);
        chk("mid_D_Instr", D_Instr, 32'h0);
        chk("mid_D_valid", {31'b0, D_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, m_pc + 32'd4);
        chk("restart_D_PC", D_PC, 32'h3000);
        chk("restart_F_PC", F_PC, 32'h3004);
        cycle(1'b0, m_pc + 32'd4);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
